// File: rtl/reg_dump_reader_if.sv
// Register-file read port plus the (index, value) dump stream of reg_dump_reader.
// master = the dump engine, slave = register file / stream consumer side.
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output dump_valid,
    input  dump_ready,
    output dump_addr,
    output dump_data,
    output dump_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  dump_valid,
    output dump_ready,
    input  dump_addr,
    input  dump_data,
    input  dump_last
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks the register file one index at a time through a
// spare read port and streams each captured (index, value) pair over valid/ready.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  reg_dump_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [ADDR_W-1:0] dump_addr_reg, dump_addr_next;
  logic [DATA_W-1:0] dump_data_reg, dump_data_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      dump_addr_reg <= '0;
      dump_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      dump_addr_reg <= dump_addr_next;
      dump_data_reg <= dump_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    dump_addr_next = dump_addr_reg;
    dump_data_next = dump_data_reg;
    case (state_reg)
      IDLE: begin
        idx_next = '0;
        if (start && !abort) state_next = READ;
      end
      READ: begin
        // Capture happens here so a later register-file write cannot disturb the beat.
        dump_addr_next = idx_reg;
        dump_data_next = bus.rd_data;
        state_next     = SEND;
      end
      SEND: begin
        if (bus.dump_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = READ;
          end
        end
      end
      DONE: begin
        idx_next   = '0;
        state_next = IDLE;
      end
      default: begin
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
    // A beat handshaking on the abort edge is already counted by the consumer.
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      idx_next   = '0;
    end
  end

  // idx_reg is a register, so the read address is registered as well.
  assign bus.rd_addr    = idx_reg;
  assign bus.dump_valid = (state_reg == SEND);
  assign bus.dump_addr  = dump_addr_reg;
  assign bus.dump_data  = dump_data_reg;
  assign bus.dump_last  = (state_reg == SEND) && (dump_addr_reg == LAST_IDX);
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a register-file model on the read port
// and a scoreboard of expected beats checked by a stream monitor.
module tb_reg_dump_reader;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;

  reg_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign dif.rd_data = regs[dif.rd_addr];

  reg_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cur_cyc = 0;
  bit    mon_en = 1'b0;

  function automatic void push_beat(input int addr, input logic [DATA_W-1:0] data, input int cyc);
    beat_t b;
    b.addr = ADDR_W'(addr);
    b.data = data;
    b.cyc  = cyc;
    sb.push_back(b);
  endfunction

  task automatic reset_regs();
    for (int k = 0; k < NUM_REGS; k++) regs[k] = DATA_W'(k);
  endtask

  // Stream monitor: every transferred beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && reset_n && dif.dump_valid && dif.dump_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got addr %0d data %h in cycle %0d, required no beat",
                 dif.dump_addr, dif.dump_data, cur_cyc);
      end else begin
        mon_e = sb.pop_front();
        if (dif.dump_addr !== mon_e.addr || dif.dump_data !== mon_e.data ||
            dif.dump_last !== (mon_e.addr == LAST) || (mon_e.cyc != 0 && cur_cyc != mon_e.cyc)) begin
          n_bad++;
          $display("FAIL beat: got addr %0d data %h last %b cycle %0d, required addr %0d data %h last %b cycle %0d",
                   dif.dump_addr, dif.dump_data, dif.dump_last, cur_cyc,
                   mon_e.addr, mon_e.data, (mon_e.addr == LAST), mon_e.cyc);
        end
      end
    end
  end

  // Starts one dump and runs it cycle by cycle; cycle 1 is the cycle after the start edge.
  task automatic run_dump(input int stall_beg, input int stall_len, input int wr_cyc,
                          input logic [DATA_W-1:0] wr_val, input int abort_cyc,
                          input int rst_cyc, input bit spam,
                          output int done_cyc, output int idle_cyc,
                          output int n_done, output int hold_err);
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    int cyc;
    done_cyc = -1; idle_cyc = -1; n_done = 0; hold_err = 0;
    h_addr = '0; h_data = '0;
    @(posedge clk); #1;
    start = 1'b1;
    dif.dump_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      cur_cyc = cyc;
      dif.dump_ready = !(cyc >= stall_beg && cyc < stall_beg + stall_len);
      abort = (cyc == abort_cyc);
      start = spam && ((cyc % 9 == 0) || cyc == 65);
      if (cyc == wr_cyc) regs[10] = wr_val;
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cyc == stall_beg) begin
        h_addr = dif.dump_addr;
        h_data = dif.dump_data;
      end
      if (cyc > stall_beg && cyc <= stall_beg + stall_len &&
          (dif.dump_addr !== h_addr || dif.dump_data !== h_data || dif.dump_valid !== 1'b1))
        hold_err++;
      if (cyc == rst_cyc) begin
        #2;
        reset_n = 1'b0;
        break;
      end
      if (busy === 1'b0) begin
        idle_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    dif.dump_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [45:0] obs;
    #2;
    obs = {busy, done, dif.dump_valid, dif.dump_last, dif.dump_addr, dif.dump_data, dif.rd_addr};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dif.dump_valid !== 1'b0 || dif.rd_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy %b valid %b rd_addr %0d, required 0 0 0",
               busy, dif.dump_valid, dif.rd_addr);
    end
  endtask

  task automatic test_full_dump();
    int dc, ic, nd, he;
    reset_regs();
    for (int k = 0; k < NUM_REGS; k++) push_beat(k, DATA_W'(k), 2 * k + 2);
    run_dump(0, 0, 0, '0, 0, 0, 1'b0, dc, ic, nd, he);
    n_cmp++;
    if (dc !== 65) begin n_bad++; $display("FAIL full_done_cycle: got %0d, required 65", dc); end
    n_cmp++;
    if (ic !== 66) begin n_bad++; $display("FAIL full_idle_cycle: got %0d, required 66", ic); end
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL full_done_count: got %0d, required 1", nd); end
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL full_beats_left: got %0d, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_stall();
    int dc, ic, nd, he;
    reset_regs();
    for (int k = 0; k < NUM_REGS; k++) push_beat(k, DATA_W'(k), (k < 5) ? 2 * k + 2 : 2 * k + 5);
    run_dump(12, 3, 0, '0, 0, 0, 1'b0, dc, ic, nd, he);
    n_cmp++;
    if (he !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles, required 0", he); end
    n_cmp++;
    if (dc !== 68) begin n_bad++; $display("FAIL stall_done_cycle: got %0d, required 68", dc); end
    n_cmp++;
    if (ic !== 69) begin n_bad++; $display("FAIL stall_idle_cycle: got %0d, required 69", ic); end
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL stall_beats_left: got %0d, required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_coherence();
    int dc, ic, nd, he;
    for (int pass = 0; pass < 2; pass++) begin
      reset_regs();
      for (int k = 0; k < NUM_REGS; k++)
        push_beat(k, (k == 10 && pass == 0) ? 32'hDEADBEEF : DATA_W'(k), 2 * k + 2);
      // x10 is read in cycle 21: the write lands just before it, or just after it.
      run_dump(0, 0, (pass == 0) ? 21 : 23, 32'hDEADBEEF, 0, 0, 1'b0, dc, ic, nd, he);
      n_cmp++;
      if (nd !== 1 || sb.size() !== 0) begin
        n_bad++;
        $display("FAIL coherence_%0d: got done %0d beats_left %0d, required 1 0", pass, nd, sb.size());
      end
      sb.delete();
    end
  endtask

  task automatic test_abort();
    int dc, ic, nd, he;
    reset_regs();
    for (int k = 0; k < 7; k++) push_beat(k, DATA_W'(k), 2 * k + 2);
    run_dump(16, 50, 0, '0, 16, 0, 1'b0, dc, ic, nd, he);
    n_cmp++;
    if (ic !== 17) begin n_bad++; $display("FAIL abort_idle_cycle: got %0d, required 17", ic); end
    n_cmp++;
    if (dif.dump_valid !== 1'b0 || dif.rd_addr !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs: got valid %b rd_addr %0d, required 0 0", dif.dump_valid, dif.rd_addr);
    end
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    n_cmp++;
    if (nd !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses, required 0", nd); end
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL abort_beats_left: got %0d, required 0", sb.size()); end
    sb.delete();
    for (int k = 0; k < NUM_REGS; k++) push_beat(k, DATA_W'(k), 2 * k + 2);
    run_dump(0, 0, 0, '0, 0, 0, 1'b0, dc, ic, nd, he);
    n_cmp++;
    if (dc !== 65 || sb.size() !== 0) begin
      n_bad++;
      $display("FAIL abort_redump: got done cycle %0d beats_left %0d, required 65 0", dc, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_start_while_busy();
    int dc, ic, nd, he;
    reset_regs();
    for (int k = 0; k < NUM_REGS; k++) push_beat(k, DATA_W'(k), 2 * k + 2);
    run_dump(0, 0, 0, '0, 0, 0, 1'b1, dc, ic, nd, he);
    n_cmp++;
    if (nd !== 1 || dc !== 65 || ic !== 66) begin
      n_bad++;
      $display("FAIL spam_timing: got done %0d at %0d idle %0d, required 1 at 65 idle 66", nd, dc, ic);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || sb.size() !== 0) begin
      n_bad++;
      $display("FAIL spam_after: got busy %b beats_left %0d, required 0 0", busy, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_dump();
    int dc, ic, nd, he;
    logic [45:0] obs;
    reset_regs();
    for (int k = 0; k < 12; k++) push_beat(k, DATA_W'(k), 2 * k + 2);
    // Beat 12 is stalled in cycle 26 and reset is asserted before it can transfer.
    run_dump(26, 10, 0, '0, 0, 26, 1'b0, dc, ic, nd, he);
    #1;
    obs = {busy, done, dif.dump_valid, dif.dump_last, dif.dump_addr, dif.dump_data, dif.rd_addr};
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL midreset_outputs: got %h, required 0", obs); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dif.dump_valid !== 1'b0 || dif.rd_addr !== '0) begin
      n_bad++;
      $display("FAIL midreset_idle: got busy %b valid %b rd_addr %0d, required 0 0 0",
               busy, dif.dump_valid, dif.rd_addr);
    end
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL midreset_beats_left: got %0d, required 0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    dif.dump_ready = 1'b1;
    reset_regs();
    test_reset();
    mon_en = 1'b1;
    test_full_dump();
    test_stall();
    test_coherence();
    test_abort();
    test_start_while_busy();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the single-cycle RISC-V core's 32×32 register file. On a `start` pulse it drives one register-file read address per register, captures the combinational read data, and streams each (index, value) pair out over a valid/ready interface. It sits beside the decode stage on a spare read port (or a debug-muxed `Rs` port). It never writes the register file.

## Interface
- `NUM_REGS`, 32, number of registers dumped (indices 0..NUM_REGS-1)
- `ADDR_W`, 5, register index width; `NUM_REGS` ≤ 2^ADDR_W
- `DATA_W`, 32, register data width
---
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a full dump; sampled only in IDLE
- `abort`  in  1  synchronous cancel of a dump in progress
- `rd_addr`  out  ADDR_W  register-file read address (to `Rs` port)
- `rd_data`  in  DATA_W  register-file read data (combinational from `rd_addr`)
- `dump_valid`  out  1  beat available
- `dump_ready`  in  1  consumer accepts beat
- `dump_addr`  out  ADDR_W  register index of current beat
- `dump_data`  out  DATA_W  captured register value
- `dump_last`  out  1  current beat is index `NUM_REGS-1`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after last beat transferred

## Operation
- FSM states: IDLE, READ, SEND, DONE; index counter `idx` (ADDR_W bits).
- IDLE: `idx`=0, `rd_addr`=0. `start`=1 → READ.
- READ: `rd_addr`=`idx`. At the clock edge, `rd_data`→`dump_data`, `idx`→`dump_addr`. Then → SEND.
- SEND: `dump_valid`=1. On `dump_valid & dump_ready`:
  - if `idx`=NUM_REGS-1 → DONE;
  - else `idx`+1 → READ.
- DONE: `done`=1 for one cycle, then → IDLE with `idx`=0.
- `rd_addr` is registered and equals `idx`.
- `dump_last` = `dump_valid & (dump_addr == NUM_REGS-1)`.
- `dump_valid` never depends combinationally on `dump_ready`.
- While SEND is stalled, `dump_addr`/`dump_data` hold stable. Later register-file writes do not alter a captured beat.
- Coherence: each value reflects register contents in that register's READ cycle. No snapshot across registers.
- `start` while `busy`: ignored. No restart, no queuing.
- `abort` in READ/SEND/DONE: → IDLE next edge. `dump_valid` drops, `idx`=0, no `done` pulse.
  - A beat with `valid & ready` at the abort edge counts as transferred.
- `abort` in IDLE: no effect. `abort` wins over `start` in the same cycle.
- Reset (any state, asynchronous): state IDLE; `idx`, `rd_addr`, `dump_addr`, `dump_data`=0; `dump_valid`, `dump_last`, `busy`, `done`=0.

## Timing
- `start` sampled at edge E0 → READ in cycle 1. First `dump_valid` in cycle 2.
- Per register: READ (1 cycle) + SEND (≥1 cycle). Zero-stall throughput: one beat per 2 cycles.
- With `dump_ready` held 1: register k valid in cycle 2k+2. Last beat in cycle 64, `done` in cycle 65, IDLE (`busy`=0) in cycle 66.
- Each stall cycle in SEND adds exactly one cycle to total latency.
- `busy` rises in cycle 1 and falls the cycle after DONE.

## Test plan
- Register file reset (Reg[k]=k), `start` 1 cycle, `dump_ready`=1 → 32 beats (addr k, data k); `dump_last` only on addr 31; `done` in cycle 65; `busy` low in cycle 66.
- Random `dump_ready` stalls (e.g. low 3 cycles on beat 5) → beat 5 holds addr 5/data 5 stable; no beat lost or duplicated; total latency = 65 + stall cycles.
- Register-file write of 0xDEADBEEF to x10, one cycle before and one cycle after x10's READ cycle → dump shows 0xDEADBEEF only in the "before" case; in the "after" case it shows 10.
- `abort` during SEND of beat 7 with `dump_ready`=0 → IDLE next cycle; no `done`; next `start` dumps from addr 0.
- `start` pulses during busy → ignored; exactly 32 beats and one `done`.
- `reset_n` asserted mid-dump (beat 12) → all outputs 0 immediately (asynchronously); after release, idle until `start`.
